// File: rtl/orv64_fp_sqrt_issue_if.sv
`timescale 1ns/1ps
// Bundle of request, sqrt-core and response signals for orv64_fp_sqrt_issue.
//   slave  : the issue block (accepts requests, drives cores, returns responses)
//   master : the surrounding pipeline plus the single/double sqrt cores
// Signals:
//   req_*          request handshake, operand, precision, rounding mode, tag
//   csr_frm        fcsr.frm used when req_frm selects dynamic rounding
//   kill           pipeline flush
//   sqrt_rs1/frm_dw  operand and DW rounding code fed to both cores
//   sqrt_s_*/d_*   single/double core result and DW status
//   resp_*         response handshake, result, fflags, illegal flag, tag
interface orv64_fp_sqrt_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_rs1;
    logic        req_is_32;
    logic [2:0]  req_frm;
    logic [4:0]  req_tag;
    logic [2:0]  csr_frm;
    logic        kill;
    logic [63:0] sqrt_rs1;
    logic [2:0]  sqrt_frm_dw;
    logic [63:0] sqrt_s_rd;
    logic [7:0]  sqrt_s_status;
    logic [63:0] sqrt_d_rd;
    logic [7:0]  sqrt_d_status;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rd;
    logic [4:0]  resp_fflags;
    logic        resp_illegal;
    logic [4:0]  resp_tag;

    modport slave (
        input  req_valid, req_rs1, req_is_32, req_frm, req_tag, csr_frm, kill,
               sqrt_s_rd, sqrt_s_status, sqrt_d_rd, sqrt_d_status, resp_ready,
        output req_ready, sqrt_rs1, sqrt_frm_dw,
               resp_valid, resp_rd, resp_fflags, resp_illegal, resp_tag
    );

    modport master (
        output req_valid, req_rs1, req_is_32, req_frm, req_tag, csr_frm, kill,
               sqrt_s_rd, sqrt_s_status, sqrt_d_rd, sqrt_d_status, resp_ready,
        input  req_ready, sqrt_rs1, sqrt_frm_dw,
               resp_valid, resp_rd, resp_fflags, resp_illegal, resp_tag
    );
endinterface

// File: rtl/orv64_fp_sqrt_issue.sv
`timescale 1ns/1ps
// Issue/capture wrapper around multicycle single and double sqrt cores.
// Registers one request, holds the core inputs stable for LATENCY cycles,
// captures the selected core's result and status, and presents a response
// until the consumer takes it. Reserved rounding modes bypass the cores.
// Ports:
//   clk    clock (rising edge)
//   rstn   asynchronous active-low reset
//   bus_io request / core / response signals (slave side)
// LATENCY: cycles the core inputs are held before sampling, legal 1..15.
module orv64_fp_sqrt_issue #(
    parameter int unsigned LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    orv64_fp_sqrt_issue_if.slave        bus_io
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rs1_q, rs1_d;
    logic        is_32_q, is_32_d;
    logic [2:0]  frm_dw_q, frm_dw_d;
    logic [4:0]  tag_q, tag_d;
    logic [63:0] rd_q, rd_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  eff_frm;
    logic [2:0]  eff_frm_dw;
    logic        eff_frm_bad;
    logic [7:0]  status;
    logic        unused_status;

    // 3'b111 in the instruction selects the dynamic mode from fcsr.
    assign eff_frm = (bus_io.req_frm == 3'b111) ? bus_io.csr_frm : bus_io.req_frm;

    // RISC-V RDN/RUP are swapped relative to the DW encoding.
    always_comb begin
        eff_frm_dw  = 3'd0;
        eff_frm_bad = 1'b0;
        case (eff_frm)
            3'd0:    eff_frm_dw = 3'd0;
            3'd1:    eff_frm_dw = 3'd1;
            3'd2:    eff_frm_dw = 3'd3;
            3'd3:    eff_frm_dw = 3'd2;
            3'd4:    eff_frm_dw = 3'd4;
            default: eff_frm_bad = 1'b1;
        endcase
    end

    assign status        = is_32_q ? bus_io.sqrt_s_status : bus_io.sqrt_d_status;
    assign unused_status = ^{status[7:6], status[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        is_32_d   = is_32_q;
        frm_dw_d  = frm_dw_q;
        tag_d     = tag_q;
        rd_d      = rd_q;
        fflags_d  = fflags_q;
        illegal_d = illegal_q;

        case (state_q)
            StIdle: begin
                if (bus_io.req_valid && !bus_io.kill) begin
                    rs1_d    = bus_io.req_rs1;
                    is_32_d  = bus_io.req_is_32;
                    tag_d    = bus_io.req_tag;
                    frm_dw_d = eff_frm_dw;
                    if (eff_frm_bad) begin
                        state_d   = StDone;
                        rd_d      = '0;
                        fflags_d  = '0;
                        illegal_d = 1'b1;
                    end else begin
                        state_d   = StWait;
                        cnt_d     = 4'(LATENCY - 1);
                        illegal_d = 1'b0;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    rd_d      = is_32_q ? bus_io.sqrt_s_rd : bus_io.sqrt_d_rd;
                    // {NV, DZ, OF, UF, NX}; UF only counts when the result is inexact.
                    fflags_d  = {status[2], 1'b0, status[4], status[3] & status[5], status[5]};
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (bus_io.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a response being consumed.
        if (bus_io.kill) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rs1_q     <= '0;
            is_32_q   <= 1'b0;
            frm_dw_q  <= '0;
            tag_q     <= '0;
            rd_q      <= '0;
            fflags_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            is_32_q   <= is_32_d;
            frm_dw_q  <= frm_dw_d;
            tag_q     <= tag_d;
            rd_q      <= rd_d;
            fflags_q  <= fflags_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus_io.req_ready    = (state_q == StIdle);
    assign bus_io.resp_valid   = (state_q == StDone);
    assign bus_io.sqrt_rs1     = rs1_q;
    assign bus_io.sqrt_frm_dw  = frm_dw_q;
    assign bus_io.resp_rd      = rd_q;
    assign bus_io.resp_fflags  = fflags_q;
    assign bus_io.resp_illegal = illegal_q;
    assign bus_io.resp_tag     = tag_q;

endmodule

// File: tb/tb_orv64_fp_sqrt_issue.sv
`timescale 1ns/1ps
// Directed bench for orv64_fp_sqrt_issue with LATENCY=2 and a behavioural
// stand-in for the single/double sqrt cores.
module tb_orv64_fp_sqrt_issue;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    orv64_fp_sqrt_issue_if bus ();

    orv64_fp_sqrt_issue #(
        .LATENCY (2)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: known operands give real sqrt results; anything else gives a
    // recognisable junk value so a wrong core or wrong operand shows up.
    always_comb begin
        bus.sqrt_s_rd     = 64'h5555_5555_5555_5555;
        bus.sqrt_s_status = 8'h3C;
        bus.sqrt_d_rd     = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.sqrt_d_status = 8'h38;
        case (bus.sqrt_rs1)
            64'hFFFF_FFFF_4080_0000: begin
                bus.sqrt_s_rd     = 64'hFFFF_FFFF_4000_0000;
                bus.sqrt_s_status = 8'h00;
            end
            64'hFFFF_FFFF_4000_0000: begin
                // Only round-up (DW code 2) lands on ...F4.
                bus.sqrt_s_rd     = (bus.sqrt_frm_dw == 3'd2) ? 64'hFFFF_FFFF_3FB5_04F4
                                                              : 64'hFFFF_FFFF_3FB5_04F3;
                bus.sqrt_s_status = 8'h20;
            end
            64'hBFF0_0000_0000_0000: begin
                bus.sqrt_d_rd     = 64'h7FF8_0000_0000_0000;
                bus.sqrt_d_status = 8'h04;
            end
            64'h0000_0000_0000_0BAD: begin
                bus.sqrt_d_rd     = 64'h0123_4567_89AB_CDEF;
                bus.sqrt_d_status = 8'h3C;
            end
            64'h0000_0000_0000_0F1A: begin
                bus.sqrt_d_rd     = 64'h0FED_CBA9_8765_4321;
                bus.sqrt_d_status = 8'h18;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [63:0] rs1;
        logic        is_32;
        logic [2:0]  frm;
        logic [2:0]  csr;
        logic [4:0]  tag;
        logic [63:0] rd;
        logic [4:0]  ff;
        logic        ill;
        logic [2:0]  dw;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request for one cycle; returns at the negedge after accept.
    task automatic start(input logic [63:0] rs1, input logic is_32, input logic [2:0] frm,
                         input logic [2:0] csr, input logic [4:0] tag);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rs1   = rs1;
        bus.req_is_32 = is_32;
        bus.req_frm   = frm;
        bus.csr_frm   = csr;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        // Scramble the request inputs: the cores must only see registered values.
        bus.req_rs1   = 64'hDEAD_BEEF_0BAD_F00D;
        bus.req_frm   = 3'd4;
        bus.csr_frm   = 3'd1;
        bus.req_is_32 = ~is_32;
        bus.req_tag   = ~tag;
    endtask

    // Cycles from the accept cycle until resp_valid, bounded.
    task automatic wait_resp(output int n);
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        start(v.rs1, v.is_32, v.frm, v.csr, v.tag);
        if (!v.ill) begin
            check("sqrt_rs1_wait", bus.sqrt_rs1, v.rs1);
            check("sqrt_frm_dw_wait", 64'(bus.sqrt_frm_dw), 64'(v.dw));
        end
        wait_resp(n);
        check("latency", 64'(n), 64'(v.lat));
        check("resp_rd", bus.resp_rd, v.rd);
        check("resp_fflags", 64'(bus.resp_fflags), 64'(v.ff));
        check("resp_illegal", 64'(bus.resp_illegal), 64'(v.ill));
        check("resp_tag", 64'(bus.resp_tag), 64'(v.tag));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("idle_after_consume", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
    endtask

    task automatic no_resp_for(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        errors = 0;
        checks = 0;
        rstn           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_rs1    = '0;
        bus.req_is_32  = 1'b0;
        bus.req_frm    = '0;
        bus.req_tag    = '0;
        bus.csr_frm    = '0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;

        //           rs1                     s32   frm   csr   tag    rd                       ff        ill   dw   lat
        vecs[0]  = '{64'hFFFF_FFFF_4080_0000, 1'b1, 3'd0, 3'd0, 5'd1,  64'hFFFF_FFFF_4000_0000, 5'b00000, 1'b0, 3'd0, 3};
        vecs[1]  = '{64'hFFFF_FFFF_4000_0000, 1'b1, 3'd1, 3'd0, 5'd2,  64'hFFFF_FFFF_3FB5_04F3, 5'b00001, 1'b0, 3'd1, 3};
        vecs[2]  = '{64'hFFFF_FFFF_4000_0000, 1'b1, 3'd3, 3'd0, 5'd3,  64'hFFFF_FFFF_3FB5_04F4, 5'b00001, 1'b0, 3'd2, 3};
        vecs[3]  = '{64'hBFF0_0000_0000_0000, 1'b0, 3'd0, 3'd0, 5'd4,  64'h7FF8_0000_0000_0000, 5'b10000, 1'b0, 3'd0, 3};
        vecs[4]  = '{64'hFFFF_FFFF_4080_0000, 1'b1, 3'd7, 3'd5, 5'd5,  64'h0,                   5'b00000, 1'b1, 3'd0, 1};
        vecs[5]  = '{64'hFFFF_FFFF_4000_0000, 1'b1, 3'd7, 3'd2, 5'd6,  64'hFFFF_FFFF_3FB5_04F3, 5'b00001, 1'b0, 3'd3, 3};
        vecs[6]  = '{64'hFFFF_FFFF_4000_0000, 1'b1, 3'd4, 3'd0, 5'd7,  64'hFFFF_FFFF_3FB5_04F3, 5'b00001, 1'b0, 3'd4, 3};
        vecs[7]  = '{64'hBFF0_0000_0000_0000, 1'b0, 3'd6, 3'd0, 5'd8,  64'h0,                   5'b00000, 1'b1, 3'd0, 1};
        vecs[8]  = '{64'h0000_0000_0000_0BAD, 1'b0, 3'd2, 3'd0, 5'd9,  64'h0123_4567_89AB_CDEF, 5'b10111, 1'b0, 3'd3, 3};
        vecs[9]  = '{64'h0000_0000_0000_0F1A, 1'b0, 3'd7, 3'd0, 5'd10, 64'h0FED_CBA9_8765_4321, 5'b00100, 1'b0, 3'd0, 3};
        vecs[10] = '{64'hFFFF_FFFF_4080_0000, 1'b1, 3'd5, 3'd3, 5'd11, 64'h0,                   5'b00000, 1'b1, 3'd0, 1};

        // Reset state.
        @(negedge clk);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_sqrt_rs1", bus.sqrt_rs1, 64'd0);
        check("rst_sqrt_frm_dw", 64'(bus.sqrt_frm_dw), 64'd0);
        check("rst_resp_fields", 64'({bus.resp_rd[4:0], bus.resp_fflags, bus.resp_illegal,
                                      bus.resp_tag}), 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Backpressure: response held for three cycles, then consumed.
        start(64'hFFFF_FFFF_4000_0000, 1'b1, 3'd3, 3'd0, 5'd20);
        wait_resp(n);
        check("bp_latency", 64'(n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid_ready", 64'({bus.resp_valid, bus.req_ready}), 64'b10);
            check("bp_hold_rd", bus.resp_rd, 64'hFFFF_FFFF_3FB5_04F4);
            check("bp_hold_flags_tag", 64'({bus.resp_fflags, bus.resp_illegal, bus.resp_tag}),
                  64'({5'b00001, 1'b0, 5'd20}));
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp_idle_after", 64'({bus.req_ready, bus.resp_valid}), 64'b10);

        // Kill in WAIT drops the operation.
        start(64'hFFFF_FFFF_4080_0000, 1'b1, 3'd0, 3'd0, 5'd21);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_wait_idle", 64'(bus.req_ready), 64'd1);
        no_resp_for("kill_wait_no_resp", 8);
        v = vecs[0];
        v.tag = 5'd22;
        run_vec(v);

        // Reset pulse in WAIT drops the operation and clears core inputs.
        start(64'hFFFF_FFFF_4000_0000, 1'b1, 3'd3, 3'd0, 5'd23);
        check("rstw_dw_before", 64'(bus.sqrt_frm_dw), 64'd2);
        rstn = 1'b0;
        #1;
        check("rstw_sqrt_rs1", bus.sqrt_rs1, 64'd0);
        check("rstw_sqrt_frm_dw", 64'(bus.sqrt_frm_dw), 64'd0);
        check("rstw_state", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        @(negedge clk);
        rstn = 1'b1;
        no_resp_for("rstw_no_resp", 8);
        v = vecs[3];
        v.tag = 5'd24;
        run_vec(v);

        // Kill in IDLE masks req_valid.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rs1   = 64'hFFFF_FFFF_4080_0000;
        bus.req_is_32 = 1'b1;
        bus.req_frm   = 3'd0;
        bus.req_tag   = 5'd25;
        bus.kill      = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        check("kill_idle_ready", 64'(bus.req_ready), 64'd1);
        no_resp_for("kill_idle_no_resp", 6);

        // Kill together with resp_ready in DONE: back to IDLE, nothing left pending.
        start(64'hBFF0_0000_0000_0000, 1'b0, 3'd0, 3'd0, 5'd26);
        wait_resp(n);
        check("kill_done_latency", 64'(n), 64'd3);
        bus.kill       = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;
        check("kill_done_idle", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        no_resp_for("kill_done_no_resp", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
